// File: rtl/spi_dac_pkg.sv
// Shared types and elaboration helpers for the multi-channel SPI DAC transmitter.
// Covers the FSM state encoding, frame-width math and parameter clamping.
package spi_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic int unsigned frame_w(input int unsigned ctrl_w, input int unsigned data_w);
    return ctrl_w + data_w;
  endfunction

  // The divider needs at least two clocks per half-period to produce separate rise/fall strobes.
  function automatic int unsigned legal_clk_div(input int unsigned clk_div);
    return (clk_div < 2) ? 2 : clk_div;
  endfunction

  function automatic int unsigned legal_min1(input int unsigned n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/spi_dac_multi_if.sv
// Sample stream plus DAC pins for spi_dac_multi; the slave modport is the DAC side.
// Handshake: a word transfers on every rising clk edge where s_valid && s_ready; s_data must hold while s_valid is high and s_ready low.
interface spi_dac_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 12
);
  import spi_dac_pkg::*;

  logic [NUM_CH*DATA_W-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     dac_cs;
  logic                     dac_sclk;
  logic [NUM_CH-1:0]        dac_mosi;
  logic                     busy;
  logic                     frame_done;
  state_e                   dbg_state;

  modport master (
    output s_data, s_valid,
    input  s_ready, dac_cs, dac_sclk, dac_mosi, busy, frame_done, dbg_state
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, dac_cs, dac_sclk, dac_mosi, busy, frame_done, dbg_state
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial clock divider: toggles sclk every CLK_DIV clks while enabled, idles high when cleared.
// rise_o/fall_o flag the clk edge on which sclk is about to change.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          term;

  assign term = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (term) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = term && !sclk_q;
  assign fall_o = term && sclk_q;

endmodule

// File: rtl/spi_dac_multi.sv
// Multi-channel SPI DAC transmitter: one-deep holding register feeding NUM_CH parallel
// shift registers that share chip select and serial clock.
module spi_dac_multi
  import spi_dac_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] CTRL_BITS = '0,
  parameter int unsigned CLK_DIV   = 32,
  parameter int unsigned CS_GAP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  spi_dac_multi_if.slave  bus
);

  localparam int unsigned FRAME_W  = frame_w(CTRL_W, DATA_W);
  localparam int unsigned DIV      = legal_clk_div(CLK_DIV);
  localparam int unsigned GAP_CLKS = legal_min1(CS_GAP) * 2 * DIV;
  localparam int unsigned BCW      = $clog2(FRAME_W + 1);
  localparam int unsigned GCW      = $clog2(GAP_CLKS);

  state_e                   state_q;
  logic                     cs_q, busy_q, frame_done_q, hold_valid_q;
  logic [NUM_CH*DATA_W-1:0] hold_q;
  logic [BCW-1:0]           bit_cnt_q;
  logic [GCW-1:0]           gap_cnt_q;
  logic [NUM_CH-1:0]        mosi;

  logic sclk, sclk_rise, sclk_fall;
  logic in_shift, start_frame, last_rise, shift_bit, accept;

  assign in_shift    = (state_q == ST_SHIFT);
  assign start_frame = (state_q == ST_IDLE) && hold_valid_q;
  assign last_rise   = in_shift && sclk_rise && (bit_cnt_q == BCW'(FRAME_W));
  assign shift_bit   = in_shift && sclk_rise && !last_rise;
  assign accept      = bus.s_valid && !hold_valid_q;

  spi_sclk_gen #(.CLK_DIV(DIV)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .en_i   (in_shift),
    .clr_i  (!in_shift),
    .sclk_o (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // The shift register MSB is the registered MOSI bit; clearing it at frame end returns MOSI to 0.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [FRAME_W-1:0] sh_q;
    logic [FRAME_W-1:0] frame;

    assign frame = {CTRL_BITS, hold_q[ch*DATA_W +: DATA_W]};

    always_ff @(posedge clk) begin
      if (reset) begin
        sh_q <= '0;
      end else if (start_frame) begin
        sh_q <= frame;
      end else if (shift_bit) begin
        sh_q <= {sh_q[FRAME_W-2:0], 1'b0};
      end else if (last_rise) begin
        sh_q <= '0;
      end
    end

    assign mosi[ch] = sh_q[FRAME_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cs_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        hold_q       <= bus.s_data;
        hold_valid_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (hold_valid_q) begin
            hold_valid_q <= 1'b0;
            cs_q         <= 1'b0;
            busy_q       <= 1'b1;
            bit_cnt_q    <= '0;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_fall) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (last_rise) begin
            cs_q         <= 1'b1;
            frame_done_q <= 1'b1;
            gap_cnt_q    <= '0;
            state_q      <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The IDLE cycle that launches the next frame is the last CS-high clk of the gap.
          if (gap_cnt_q == GCW'(GAP_CLKS - 2)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready    = !hold_valid_q;
  assign bus.dac_cs     = cs_q;
  assign bus.dac_sclk   = sclk;
  assign bus.dac_mosi   = mosi;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dbg_state  = state_q;

endmodule
